ibpl_led_serializer: RTL

//  Downstream of the interbackplane cardlet plugins: gathers each slot's diob_led1/diob_led2 bytes and

---
 rtl/ibpl_led_pkg.sv | 21 ++
 rtl/ibpl_led_stretch.sv | 40 ++++
 rtl/ibpl_led_serializer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ibpl_led_pkg.sv
// Shared types and helpers for the backplane LED serializer.
// State encoding and slot/bit placement in the serial chain.
package ibpl_led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int LEDS_PER_SLOT = 16;

  // Chain bit position for slot, byte select (0=led1, 1=led2), bit.
  // The chain shifts MSB first, so the highest slot's led2[7] leads.
  function automatic int led_bit(int slot, int sel, int b);
    return slot * LEDS_PER_SLOT + sel * 8 + b;
  endfunction

endpackage

// File: rtl/ibpl_led_stretch.sv
// Retriggerable per-bit on-stretcher for LED inputs.
// Used by ibpl_led_serializer when IBPL_LED_STRETCH_EN is defined.
module ibpl_led_stretch
  import ibpl_led_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int STRETCH_CYC = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bits,
  output logic [WIDTH-1:0] held
);

  localparam int CW = $clog2(STRETCH_CYC + 1);

  logic [CW-1:0] cnt [WIDTH];

  // Reload on a lit input, otherwise count down to zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (bits[i]) begin
        cnt[i] <= CW'(STRETCH_CYC - 1);
      end else if (cnt[i] != '0) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // A bit stays lit while its input or its counter is active.
  always_comb begin
    held = '0;
    for (int i = 0; i < WIDTH; i++) begin
      held[i] = bits[i] | (cnt[i] != '0);
    end
  end

endmodule

// File: rtl/ibpl_led_serializer.sv
// Snapshot -> shift -> latch driver for the backplane 74HC595 LED chain.
// Optional input stretching is enabled by defining IBPL_LED_STRETCH_EN.
module ibpl_led_serializer
  import ibpl_led_pkg::*;
#(
  parameter int N_CARDLETS   = 4,
  parameter int CLK_DIV      = 4,
  parameter int REFRESH_CYC  = 50000,
  parameter int BLINK_FRAMES = 8,
  parameter int STRETCH_CYC  = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*N_CARDLETS-1:0] led1_in,
  input  logic [8*N_CARDLETS-1:0] led2_in,
  input  logic [N_CARDLETS-1:0]   plugin_err,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch,
  output logic                    ser_oe_n,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int NBITS = LEDS_PER_SLOT * N_CARDLETS;
  localparam int TW = $clog2(REFRESH_CYC);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NBITS + 1);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (REFRESH_CYC < 2 * CLK_DIV * (NBITS + 1)) begin : g_bad_refresh
    $error("REFRESH_CYC too short for one frame");
  end
  if (STRETCH_CYC < 1) begin : g_bad_stretch
    $error("STRETCH_CYC must be at least 1");
  end

  state_t            state;
  state_t            next;
  logic [TW-1:0]     timer;
  logic              pending;
  logic              kick;
  logic [DW-1:0]     div;
  logic              div_end;
  logic [IW-1:0]     idx;
  logic [NBITS-1:0]  sr;
  logic [NBITS-1:0]  snap;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic [8*N_CARDLETS-1:0] led1_s;
  logic [8*N_CARDLETS-1:0] led2_s;

`ifdef IBPL_LED_STRETCH_EN
  ibpl_led_stretch #(
    .WIDTH       (16 * N_CARDLETS),
    .STRETCH_CYC (STRETCH_CYC)
  ) u_stretch (
    .clk  (clk),
    .rst  (rst),
    .bits ({led2_in, led1_in}),
    .held ({led2_s, led1_s})
  );
`else
  assign led1_s = led1_in;
  assign led2_s = led2_in;
`endif

  // Error slots show the blink phase on all 16 LEDs.
  for (genvar k = 0; k < N_CARDLETS; k++) begin : g_slot
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign snap[led_bit(k, 0, b)] =
        plugin_err[k] ? phase : led1_s[8*k+b];
      assign snap[led_bit(k, 1, b)] =
        plugin_err[k] ? phase : led2_s[8*k+b];
    end
  end

  assign div_end = (div == DW'(CLK_DIV - 1));

  // Refresh timer; a wrap requests a frame, kick starts the first one.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      pending <= 1'b0;
      kick    <= 1'b1;
    end else begin
      if (timer == TW'(REFRESH_CYC - 1)) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (state == LOAD) begin
        pending <= 1'b0;
        kick    <= 1'b0;
      end
      if (timer == TW'(REFRESH_CYC - 1)) begin
        pending <= 1'b1;
      end
    end
  end

  // Next-state and chain pin decode.
  always_comb begin
    next      = state;
    ser_clk   = 1'b0;
    ser_latch = 1'b0;
    ser_data  = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (pending || kick) next = LOAD;
      end
      LOAD: begin
        next = SHIFT_LO;
      end
      SHIFT_LO: begin
        ser_data = sr[NBITS-1];
        if (div_end) next = SHIFT_HI;
      end
      SHIFT_HI: begin
        ser_clk  = 1'b1;
        ser_data = sr[NBITS-1];
        if (div_end) begin
          next = (idx == IW'(NBITS - 1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        ser_latch = 1'b1;
        if (div_end) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // State register, phase divider, shift register and frame bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      idx        <= '0;
      sr         <= '0;
      frame_done <= 1'b0;
      ser_oe_n   <= 1'b1;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else begin
      state      <= next;
      frame_done <= 1'b0;
      if (next != state || state == IDLE) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
      if (state == LOAD) begin
        sr  <= snap;
        idx <= '0;
      end
      if (state == SHIFT_HI && div_end) begin
        sr  <= {sr[NBITS-2:0], 1'b0};
        idx <= idx + 1'b1;
      end
      if (state == LATCH && div_end) begin
        frame_done <= 1'b1;
        ser_oe_n   <= 1'b0;
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
